// File: rtl/seq_detect_ctrl_if.sv
// Bus bundle for seq_detect_ctrl: configuration, session control, serial stream and status.
// The master side drives config/control/stream; the slave side (the controller) returns status.
interface seq_detect_ctrl_if #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TO_W    = 16
);
  logic               cfg_we;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [3:0]         cfg_len;
  logic [CNT_W-1:0]   cfg_target;
  logic [TO_W-1:0]    cfg_timeout;
  logic               start;
  logic               abort;
  logic               x_valid;
  logic               x;
  logic               match;
  logic [CNT_W-1:0]   match_cnt;
  logic               busy;
  logic               done;
  logic               timeout_flag;
  logic               cfg_err;

  modport master (
    output cfg_we, cfg_pattern, cfg_len, cfg_target, cfg_timeout,
    output start, abort, x_valid, x,
    input  match, match_cnt, busy, done, timeout_flag, cfg_err
  );

  modport slave (
    input  cfg_we, cfg_pattern, cfg_len, cfg_target, cfg_timeout,
    input  start, abort, x_valid, x,
    output match, match_cnt, busy, done, timeout_flag, cfg_err
  );
endinterface

// File: rtl/seq_detect_ctrl.sv
// Programmable serial pattern detector with bounded sessions (target count, idle timeout, abort).
// Overlapping matches are counted; all status outputs are registered.
module seq_detect_ctrl #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TO_W    = 16
) (
  input logic              clk,
  input logic              rst,
  seq_detect_ctrl_if.slave bus
);
  localparam int unsigned LEN_W = 4;
  localparam int unsigned BS_W  = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10,
    ILL  = 2'b11
  } state_t;

  state_t state_q, state_d;

  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   target_q, target_d;
  logic [TO_W-1:0]    timeout_q, timeout_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [BS_W-1:0]    bits_q, bits_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TO_W-1:0]    idle_q, idle_d;
  logic               match_q, match_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               tflag_q, tflag_d;
  logic               cerr_q, cerr_d;

  logic               cfg_open;
  logic               cfg_take;
  logic [LEN_W-1:0]   eff_len;
  logic               start_ok;
  logic               start_bad;
  logic [MAX_LEN-1:0] hist_n;
  logic [BS_W-1:0]    bits_n;
  logic [MAX_LEN-1:0] mask;
  logic               hit;
  logic [CNT_W-1:0]   cnt_inc;
  logic [TO_W-1:0]    idle_inc;
  logic               expire;
  logic               tgt_hit;

  // Start qualification: a same-cycle config write is seen by the start.
  always_comb begin
    cfg_open  = (state_q == IDLE) || (state_q == DONE);
    cfg_take  = cfg_open && bus.cfg_we;
    eff_len   = cfg_take ? bus.cfg_len : len_q;
    start_ok  = cfg_open && bus.start && (|eff_len) && (32'(eff_len) <= MAX_LEN);
    start_bad = cfg_open && bus.start && !start_ok;
  end

  // Stream evaluation: only the len newest history bits take part in the compare.
  always_comb begin
    hist_n = {hist_q[MAX_LEN-2:0], bus.x};
    bits_n = (32'(bits_q) >= MAX_LEN) ? bits_q : bits_q + BS_W'(1);
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (32'(len_q) > 32'(i));
    end
    hit      = (state_q == RUN) && bus.x_valid &&
               (32'(bits_n) >= 32'(len_q)) &&
               ((hist_n & mask) == (pattern_q & mask));
    cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    idle_inc = idle_q + TO_W'(1);
    expire   = (state_q == RUN) && !hit && (|timeout_q) && (idle_inc >= timeout_q);
    tgt_hit  = hit && (|target_q) && (cnt_inc == target_q);
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: abort beats match/timeout; the encoding 2'b11 falls back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_ok) state_d = RUN;
      end
      RUN: begin
        if (bus.abort)                state_d = IDLE;
        else if (tgt_hit || expire)   state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    pattern_d = pattern_q;
    len_d     = len_q;
    target_d  = target_q;
    timeout_d = timeout_q;
    hist_d    = hist_q;
    bits_d    = bits_q;
    cnt_d     = cnt_q;
    idle_d    = idle_q;
    match_d   = 1'b0;
    tflag_d   = tflag_q;
    cerr_d    = cerr_q;
    busy_d    = (state_d == RUN);
    done_d    = (state_d == DONE);

    if (cfg_take) begin
      pattern_d = bus.cfg_pattern;
      len_d     = bus.cfg_len;
      target_d  = bus.cfg_target;
      timeout_d = bus.cfg_timeout;
    end

    if (start_ok) begin
      hist_d  = '0;
      bits_d  = '0;
      cnt_d   = '0;
      idle_d  = '0;
      tflag_d = 1'b0;
      cerr_d  = 1'b0;
    end else if (start_bad) begin
      cerr_d  = 1'b1;
    end

    // Session activity; x_valid gaps freeze history but not the idle counter.
    if ((state_q == RUN) && !bus.abort) begin
      if (bus.x_valid) begin
        hist_d = hist_n;
        bits_d = bits_n;
      end
      if (hit) begin
        match_d = 1'b1;
        cnt_d   = cnt_inc;
        idle_d  = '0;
      end else if (|timeout_q) begin
        idle_d = idle_inc;
        if (expire) tflag_d = 1'b1;
      end
    end
  end

  // Datapath and status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pattern_q <= '0;
      len_q     <= '0;
      target_q  <= '0;
      timeout_q <= '0;
      hist_q    <= '0;
      bits_q    <= '0;
      cnt_q     <= '0;
      idle_q    <= '0;
      match_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tflag_q   <= 1'b0;
      cerr_q    <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      len_q     <= len_d;
      target_q  <= target_d;
      timeout_q <= timeout_d;
      hist_q    <= hist_d;
      bits_q    <= bits_d;
      cnt_q     <= cnt_d;
      idle_q    <= idle_d;
      match_q   <= match_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      tflag_q   <= tflag_d;
      cerr_q    <= cerr_d;
    end
  end

  assign bus.match        = match_q;
  assign bus.match_cnt    = cnt_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.timeout_flag = tflag_q;
  assign bus.cfg_err      = cerr_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Scoreboard bench for seq_detect_ctrl: a queue-based session model predicts every cycle's outputs,
// a separate monitor pops and compares; directed scenarios plus a randomized phase.
module tb_seq_detect_ctrl;
  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned TO_W    = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seq_detect_ctrl_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .TO_W(TO_W)) bus ();

  seq_detect_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .TO_W(TO_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       match;
    logic [7:0] cnt;
    logic       busy;
    logic       done;
    logic       tflag;
    logic       cerr;
  } exp_t;

  exp_t expq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference session model (mode: 0 idle, 1 running, 2 finished).
  int         m_mode, m_len, m_tgt, m_to, m_cnt, m_idle;
  logic [7:0] m_pat;
  bit         m_hist[$];
  bit         m_match, m_tflag, m_cerr;

  function automatic bit tail_match();
    if (m_hist.size() < m_len) return 1'b0;
    for (int k = 0; k < m_len; k++)
      if (m_hist[m_hist.size() - 1 - k] != m_pat[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    bit open, got;
    m_match = 1'b0;
    if (!rst) begin
      m_mode = 0; m_len = 0; m_tgt = 0; m_to = 0; m_cnt = 0; m_idle = 0;
      m_pat = '0; m_hist.delete(); m_tflag = 1'b0; m_cerr = 1'b0;
      return;
    end
    open = (m_mode != 1);
    if (open && bus.cfg_we) begin
      m_pat = bus.cfg_pattern; m_len = int'(bus.cfg_len);
      m_tgt = int'(bus.cfg_target); m_to = int'(bus.cfg_timeout);
    end
    if (open && bus.start) begin
      if (m_len >= 1 && m_len <= int'(MAX_LEN)) begin
        m_mode = 1; m_hist.delete(); m_cnt = 0; m_idle = 0; m_tflag = 1'b0; m_cerr = 1'b0;
      end else begin
        m_cerr = 1'b1;
      end
    end else if (m_mode == 1) begin
      if (bus.abort) begin
        m_mode = 0;
      end else begin
        got = 1'b0;
        if (bus.x_valid) begin
          m_hist.push_back(bus.x);
          if (m_hist.size() > 16) void'(m_hist.pop_front());
          got = tail_match();
        end
        if (got) begin
          m_match = 1'b1;
          if (m_cnt < 255) m_cnt++;
          m_idle = 0;
          if (m_tgt != 0 && m_cnt == m_tgt) m_mode = 2;
        end else if (m_to != 0) begin
          m_idle++;
          if (m_idle >= m_to) begin m_mode = 2; m_tflag = 1'b1; end
        end
      end
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.match = m_match;
    e.cnt   = 8'(m_cnt);
    e.busy  = (m_mode == 1);
    e.done  = (m_mode == 2);
    e.tflag = m_tflag;
    e.cerr  = m_cerr;
    expq.push_back(e);
  endtask

  task automatic cyc(input logic we, input logic [7:0] pat, input logic [3:0] len,
                     input logic [7:0] tgt, input logic [15:0] to,
                     input logic st, input logic ab, input logic xv, input logic xb);
    @(negedge clk);
    bus.cfg_we = we; bus.cfg_pattern = pat; bus.cfg_len = len;
    bus.cfg_target = tgt; bus.cfg_timeout = to;
    bus.start = st; bus.abort = ab; bus.x_valid = xv; bus.x = xb;
    model_step();
    push_exp();
  endtask

  task automatic sbit(input logic xv, input logic xb);
    cyc(1'b0, 8'h00, 4'd0, 8'd0, 16'd0, 1'b0, 1'b0, xv, xb);
  endtask

  task automatic rst_cyc(input logic r);
    @(negedge clk);
    rst = r;
    bus.cfg_we = 1'b0; bus.start = 1'b0; bus.abort = 1'b0; bus.x_valid = 1'b0; bus.x = 1'b0;
    model_step();
    push_exp();
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compare every registered output against the predicted tuple.
  initial begin
    exp_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        a.match = bus.match; a.cnt = bus.match_cnt; a.busy = bus.busy;
        a.done = bus.done; a.tflag = bus.timeout_flag; a.cerr = bus.cfg_err;
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL outputs t=%0t got m=%0b cnt=%0d busy=%0b done=%0b to=%0b err=%0b want m=%0b cnt=%0d busy=%0b done=%0b to=%0b err=%0b",
                   $time, a.match, a.cnt, a.busy, a.done, a.tflag, a.cerr,
                   e.match, e.cnt, e.busy, e.done, e.tflag, e.cerr);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [3:0] rl;
    bus.cfg_we = 1'b0; bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_target = '0;
    bus.cfg_timeout = '0; bus.start = 1'b0; bus.abort = 1'b0; bus.x_valid = 1'b0; bus.x = 1'b0;

    rst_cyc(1'b0);
    rst_cyc(1'b0);
    settle();
    expect_now("reset_busy", int'(bus.busy), 0);
    expect_now("reset_cnt", int'(bus.match_cnt), 0);
    rst_cyc(1'b1);

    // T1: overlapping matches of 1001
    cyc(1'b1, 8'b1001, 4'd4, 8'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 4'd0, 8'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    sbit(1, 1); sbit(1, 0); sbit(1, 0); sbit(1, 1); sbit(1, 0); sbit(1, 0); sbit(1, 1);
    settle();
    expect_now("t1_cnt", int'(bus.match_cnt), 2);
    expect_now("t1_busy", int'(bus.busy), 1);
    expect_now("t1_match", int'(bus.match), 1);
    cyc(1'b0, 8'h00, 4'd0, 8'd0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0);

    // T2: target 2, config and start together
    cyc(1'b1, 8'b1001, 4'd4, 8'd2, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    sbit(1, 1); sbit(1, 0); sbit(1, 0); sbit(1, 1); sbit(1, 0); sbit(1, 0); sbit(1, 1);
    settle();
    expect_now("t2_done", int'(bus.done), 1);
    expect_now("t2_busy", int'(bus.busy), 0);
    expect_now("t2_match", int'(bus.match), 1);
    sbit(1, 0); sbit(1, 0); sbit(1, 1);
    settle();
    expect_now("t2_cnt_hold", int'(bus.match_cnt), 2);

    // T3: idle timeout of 5 cycles
    cyc(1'b1, 8'b111, 4'd3, 8'd0, 16'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    sbit(0, 1); sbit(0, 1); sbit(0, 1); sbit(0, 1);
    settle();
    expect_now("t3_not_yet", int'(bus.done), 0);
    sbit(0, 1);
    settle();
    expect_now("t3_tflag", int'(bus.timeout_flag), 1);
    expect_now("t3_done", int'(bus.done), 1);

    // T4: gapped stream, then abort
    cyc(1'b1, 8'b1001, 4'd4, 8'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    sbit(1, 1); sbit(0, 0); sbit(1, 0); sbit(0, 1); sbit(1, 0); sbit(0, 0); sbit(1, 1); sbit(0, 1);
    settle();
    expect_now("t4_cnt", int'(bus.match_cnt), 1);
    cyc(1'b0, 8'h00, 4'd0, 8'd0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    settle();
    expect_now("t4_abort_busy", int'(bus.busy), 0);
    expect_now("t4_abort_cnt", int'(bus.match_cnt), 1);

    // T5: illegal length, then legal start
    cyc(1'b1, 8'b11, 4'd0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 4'd0, 8'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    expect_now("t5_err", int'(bus.cfg_err), 1);
    expect_now("t5_idle", int'(bus.busy), 0);
    cyc(1'b1, 8'b11, 4'd9, 8'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'b11, 4'd2, 8'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    expect_now("t5_run", int'(bus.busy), 1);
    expect_now("t5_err_clr", int'(bus.cfg_err), 0);

    // T6: reset mid-session
    cyc(1'b0, 8'h00, 4'd0, 8'd0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 8'b1001, 4'd4, 8'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    sbit(1, 1); sbit(1, 0); sbit(1, 0);
    rst_cyc(1'b0);
    settle();
    expect_now("t6_busy", int'(bus.busy), 0);
    rst_cyc(1'b1);
    cyc(1'b1, 8'b1001, 4'd4, 8'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    sbit(1, 1);
    settle();
    expect_now("t6_no_match", int'(bus.match), 0);

    // Counter saturation with a 1-bit pattern
    cyc(1'b0, 8'h00, 4'd0, 8'd0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 8'b1, 4'd1, 8'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 270; i++) sbit(1, 1);
    settle();
    expect_now("sat_cnt", int'(bus.match_cnt), 255);

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        rst_cyc(1'b0);
        rst_cyc(1'b1);
      end else begin
        r = int'($urandom_range(0, 9));
        if (r < 6)      rl = 4'($urandom_range(1, 3));
        else if (r < 8) rl = 4'($urandom_range(4, 8));
        else if (r == 8) rl = 4'd0;
        else            rl = 4'($urandom_range(9, 15));
        cyc(($urandom_range(0, 99) < 15), 8'($urandom()), rl,
            8'($urandom_range(0, 4)), 16'($urandom_range(0, 12)),
            ($urandom_range(0, 99) < ((m_mode != 1) ? 20 : 3)),
            ($urandom_range(0, 199) < 2),
            ($urandom_range(0, 99) < 75), 1'($urandom_range(0, 1)));
      end
    end

    settle();
    for (int i = 0; i < 10 && expq.size() > 0; i++) @(posedge clk);
    #2;
    if (expq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d predictions left, wanted 0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
